// File: rtl/change_dispenser_pkg.sv
// Shared state codes, coin constants and greedy-selection helpers for the change dispenser.
// The optional coin counter is enabled by defining PAYOUT_COUNT_EN.
package change_dispenser_pkg;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSelect = 3'd1;
  localparam logic [2:0] StPulse  = 3'd2;
  localparam logic [2:0] StGap    = 3'd3;
  localparam logic [2:0] StFinish = 3'd4;

  localparam int unsigned COIN_Q = 25;
  localparam int unsigned COIN_D = 10;
  localparam int unsigned COIN_N = 5;

  localparam int unsigned COUNT_W   = 6;
  localparam int unsigned COUNT_MAX = 63;

  typedef enum logic [1:0] {
    CoinNone,
    CoinQ,
    CoinD,
    CoinN
  } coin_sel_e;

  // Largest coin that still fits in the balance; CoinNone below a nickel.
  function automatic coin_sel_e pick_coin(input int unsigned value);
    coin_sel_e sel;
    if (value >= COIN_Q) begin
      sel = CoinQ;
    end else if (value >= COIN_D) begin
      sel = CoinD;
    end else if (value >= COIN_N) begin
      sel = CoinN;
    end else begin
      sel = CoinNone;
    end
    return sel;
  endfunction

  function automatic int unsigned coin_value(input coin_sel_e sel);
    int unsigned value;
    case (sel)
      CoinQ:   value = COIN_Q;
      CoinD:   value = COIN_D;
      CoinN:   value = COIN_N;
      default: value = 0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request/status bundle between the vending FSM (master) and the change dispenser (slave).
// coin_count exists only when PAYOUT_COUNT_EN is defined.
interface change_dispenser_if #(
  parameter int unsigned AMOUNT_W = 8
);

  logic                start;
  logic [AMOUNT_W-1:0] amount;
  logic                busy;
  logic                done;
  logic                coin_out_25;
  logic                coin_out_10;
  logic                coin_out_5;
  logic [AMOUNT_W-1:0] remaining;
  logic                error;
`ifdef PAYOUT_COUNT_EN
  logic [5:0]          coin_count;
`endif

`ifdef PAYOUT_COUNT_EN
  modport master (
    output start,
    output amount,
    input  busy,
    input  done,
    input  coin_out_25,
    input  coin_out_10,
    input  coin_out_5,
    input  remaining,
    input  error,
    input  coin_count
  );

  modport slave (
    input  start,
    input  amount,
    output busy,
    output done,
    output coin_out_25,
    output coin_out_10,
    output coin_out_5,
    output remaining,
    output error,
    output coin_count
  );
`else
  modport master (
    output start,
    output amount,
    input  busy,
    input  done,
    input  coin_out_25,
    input  coin_out_10,
    input  coin_out_5,
    input  remaining,
    input  error
  );

  modport slave (
    input  start,
    input  amount,
    output busy,
    output done,
    output coin_out_25,
    output coin_out_10,
    output coin_out_5,
    output remaining,
    output error
  );
`endif

endinterface

// File: rtl/change_dispenser_payout_timer.sv
// Loadable down-counter shared by the ejector pulse and settle-gap phases.
// Stops at zero; o_zero flags expiry. Unaffected by PAYOUT_COUNT_EN.
module change_dispenser_payout_timer #(
  parameter int unsigned TIMER_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  output logic               o_zero
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - TIMER_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Converts a change amount into greedy 25/10/5 ejector pulses separated by settle gaps.
// Define PAYOUT_COUNT_EN to add the saturating coin_count output.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned AMOUNT_W     = 8,
  parameter int unsigned PULSE_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES   = 12_500_000
) (
  input  logic               clk,
  input  logic               reset_n,
  change_dispenser_if.slave  bus
);

  localparam int unsigned TIMER_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

  logic [2:0]          r_state;
  logic [2:0]          w_state_next;
  coin_sel_e           r_coin;
  coin_sel_e           w_coin_next;
  logic [AMOUNT_W-1:0] r_remaining;
  logic [AMOUNT_W-1:0] w_remaining_next;
  logic                r_error;
  logic                w_error_next;
  coin_sel_e           w_pick;
  logic                w_start_acc;
  logic                w_tmr_load;
  logic [TIMER_W-1:0]  w_tmr_val;
  logic                w_tmr_zero;

  assign w_pick      = pick_coin(32'(r_remaining));
  assign w_start_acc = (r_state == StIdle) && bus.start;

  change_dispenser_payout_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_comb begin
    w_state_next     = r_state;
    w_coin_next      = r_coin;
    w_remaining_next = r_remaining;
    w_error_next     = r_error;
    w_tmr_load       = 1'b0;
    w_tmr_val        = '0;
    case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_remaining_next = bus.amount;
          w_error_next     = 1'b0;
          w_coin_next      = CoinNone;
          w_state_next     = StSelect;
        end
      end
      StSelect: begin
        if (w_pick != CoinNone) begin
          w_coin_next      = w_pick;
          w_remaining_next = r_remaining - AMOUNT_W'(coin_value(w_pick));
          w_tmr_load       = 1'b1;
          w_tmr_val        = TIMER_W'(PULSE_CYCLES - 1);
          w_state_next     = StPulse;
        end else begin
          // A 1..4 cent residual cannot be paid; it stays visible in remaining.
          w_error_next = (r_remaining != '0);
          w_state_next = StFinish;
        end
      end
      StPulse: begin
        if (w_tmr_zero) begin
          w_tmr_load   = 1'b1;
          w_tmr_val    = TIMER_W'(GAP_CYCLES - 1);
          w_state_next = StGap;
        end
      end
      StGap: begin
        if (w_tmr_zero) begin
          w_state_next = StSelect;
        end
      end
      StFinish: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_coin      <= CoinNone;
      r_remaining <= '0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_coin      <= w_coin_next;
      r_remaining <= w_remaining_next;
      r_error     <= w_error_next;
    end
  end

  // Ejector lines decode from state plus the latched coin, so at most one is ever high.
  assign bus.busy        = (r_state != StIdle);
  assign bus.done        = (r_state == StFinish);
  assign bus.coin_out_25 = (r_state == StPulse) && (r_coin == CoinQ);
  assign bus.coin_out_10 = (r_state == StPulse) && (r_coin == CoinD);
  assign bus.coin_out_5  = (r_state == StPulse) && (r_coin == CoinN);
  assign bus.remaining   = r_remaining;
  assign bus.error       = r_error;

`ifdef PAYOUT_COUNT_EN
  logic [COUNT_W-1:0] r_coin_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_coin_count <= '0;
    end else if (w_start_acc) begin
      r_coin_count <= '0;
    end else if ((r_state == StSelect) && (w_pick != CoinNone) &&
                 (r_coin_count != COUNT_W'(COUNT_MAX))) begin
      r_coin_count <= r_coin_count + COUNT_W'(1);
    end
  end

  assign bus.coin_count = r_coin_count;
`else
  logic w_unused;
  assign w_unused = w_start_acc;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Randomised and directed bench for change_dispenser against a greedy-payout timing model.
// Also checks coin_count when PAYOUT_COUNT_EN is defined.
module tb_change_dispenser;

  localparam int unsigned AW = 8;
  localparam int P = 4;
  localparam int G = 2;
  localparam int T = P + G + 1;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  change_dispenser_if #(.AMOUNT_W(AW)) bus ();

  change_dispenser #(
    .AMOUNT_W     (AW),
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Greedy breakdown by plain division: list of coin values, largest first.
  function automatic void breakdown(input int amt, output int coins[$], output int residual);
    int a;
    coins = {};
    a = amt;
    for (int i = 0; i < amt / 25; i++) coins.push_back(25);
    a = a % 25;
    for (int i = 0; i < a / 10; i++) coins.push_back(10);
    a = a % 10;
    for (int i = 0; i < a / 5; i++) coins.push_back(5);
    residual = a % 5;
  endfunction

  // Expected {busy,done,c25,c10,c5,error,remaining} k edges after the start edge (k=1 is it).
  function automatic logic [13:0] model(input int amt, input int k);
    int   coins[$];
    int   residual;
    int   fin;
    int   rem;
    logic c25, c10, c5;
    breakdown(amt, coins, residual);
    fin = 2 + coins.size() * T;
    rem = amt;
    c25 = 1'b0;
    c10 = 1'b0;
    c5  = 1'b0;
    for (int i = 0; i < coins.size(); i++) begin
      if (k >= 2 + i * T) rem -= coins[i];
      if (k >= 2 + i * T && k < 2 + i * T + P) begin
        c25 = (coins[i] == 25);
        c10 = (coins[i] == 10);
        c5  = (coins[i] == 5);
      end
    end
    return {(k >= 1 && k <= fin), (k == fin), c25, c10, c5,
            (k >= fin && residual != 0), 8'(rem)};
  endfunction

  function automatic int count_model(input int amt, input int k);
    int coins[$];
    int residual;
    int n;
    breakdown(amt, coins, residual);
    n = 0;
    for (int i = 0; i < coins.size(); i++) if (k >= 2 + i * T) n++;
    return (n > 63) ? 63 : n;
  endfunction

  function automatic logic [13:0] obs_vec();
    return {bus.busy, bus.done, bus.coin_out_25, bus.coin_out_10, bus.coin_out_5,
            bus.error, bus.remaining};
  endfunction

  task automatic check_vec(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_count(input string tag, input int exp);
`ifdef PAYOUT_COUNT_EN
    n_tests++;
    assert (int'(bus.coin_count) === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, bus.coin_count, exp);
    end
`else
    if (tag.len() < 0 || exp < 0) $display("unreachable");
`endif
  endtask

  // Pays amt; optionally re-asserts start (amount 200) so it is sampled at edge restart_at,
  // or pulls reset at edge abort_at.
  task automatic run_payout(input int amt, input int restart_at, input int abort_at);
    int coins[$];
    int residual;
    int fin;
    breakdown(amt, coins, residual);
    fin = 2 + coins.size() * T;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.amount = 8'(amt);
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.amount = 8'($urandom);
    for (int k = 1; k <= fin + 2; k++) begin
      check_vec($sformatf("amt%0d_k%0d", amt, k), obs_vec(), model(amt, k));
      check_count($sformatf("count_amt%0d_k%0d", amt, k), count_model(amt, k));
      if (k == abort_at) begin
        reset_n = 1'b0;
        #1;
        check_vec($sformatf("abort_amt%0d", amt), obs_vec(), 14'd0);
        check_count("abort_count", 0);
        for (int j = 0; j < 2; j++) begin
          @(posedge clk);
          #1;
          check_vec($sformatf("abort_hold%0d", j), obs_vec(), 14'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
          @(posedge clk);
          #1;
          check_vec($sformatf("abort_idle%0d", j), obs_vec(), 14'd0);
        end
        return;
      end
      @(negedge clk);
      if (k + 1 == restart_at) begin
        bus.start  = 1'b1;
        bus.amount = 8'd200;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    bus.start  = 1'b0;
    bus.amount = '0;
    #1;
    check_vec("reset_async", obs_vec(), 14'd0);
    check_count("reset_count", 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_vec("reset_idle", obs_vec(), 14'd0);

    run_payout(40, -1, -1);
    run_payout(0, -1, -1);
    run_payout(33, -1, -1);
    run_payout(30, 3, -1);
    run_payout(100, -1, 2 + T + 1);
    run_payout(10, -1, -1);
    run_payout(95, -1, -1);
    check_count("count_after_95", 5);
    run_payout(255, -1, -1);
    run_payout(4, -1, -1);
    for (int r = 0; r < 10; r++) begin
      run_payout(int'($urandom_range(0, 255)), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
